sdram_arbit: RTL
================

// Module: sdram_arbit
// PURPOSE
//  Command arbiter in front of the SDRAM pins. Grants the bus to one of init, auto-refresh, write or read
//  sub-blocks; forwards the granted block's {cs_n,ras_n,cas_n,we_n}/ba/addr to the device.
//  Issues the level enables (aref/write/read start) that the sub-blocks sample in their IDLE states.
// PARAMETERS
//  GRANT_TIMEOUT  1023  max cycles a grant may stay open without a done pulse; 10-bit counter
// PORTS
//  i_sysclk        in   1   100 MHz system clock
//  i_sysrst_n      in   1   async active-low reset
//  i_init_done     in   1   init sequence complete; level
//  i_init_cmd      in   4   init {cs_n,ras_n,cas_n,we_n}
//  i_init_ba       in   2   init bank
//  i_init_addr     in   13  init address
//  i_aref_req      in   1   refresh request; level, held until o_aref_en seen
//  i_aref_done     in   1   refresh complete; 1-cycle pulse
//  i_aref_cmd/ba/addr in 4/2/13  refresh command bus
//  i_wr_req        in   1   write request; level
//  i_wr_done       in   1   write complete; 1-cycle pulse
//  i_wr_cmd/ba/addr in 4/2/13  write command bus
//  i_wr_sdram_en   in   1   write block driving data this cycle
//  i_wr_sdram_data in   16  write data
//  i_rd_req        in   1   read request; level
//  i_rd_done       in   1   read complete; 1-cycle pulse
//  i_rd_cmd/ba/addr in 4/2/13  read command bus
//  o_aref_en/o_wr_en/o_rd_en out 1  grant enables (one-hot or all 0)
//  o_sdram_cke     out  1   clock enable, constant 1 after reset
//  o_sdram_cs_n/ras_n/cas_n/we_n out 1  device command pins
//  o_sdram_ba      out  2   device bank
//  o_sdram_addr    out  13  device address
//  o_sdram_dq_out  out  16  data to pad
//  o_sdram_dq_oe   out  1   pad output enable
//  o_arb_err       out  1   1-cycle pulse on grant timeout
// BEHAVIOUR
//  States: ARB_INIT -> ARB_IDLE; IDLE -> ARB_AREF | ARB_WRITE | ARB_READ; each -> IDLE on its done pulse.
//  INIT: leave to IDLE on first cycle i_init_done=1; requests ignored while in INIT.
//  IDLE arbitration, fixed priority aref > write > read; state registered, grant starts next cycle.
//  Enables combinational from state: o_aref_en=(AREF), o_wr_en=(WRITE), o_rd_en=(READ).
//   Leaving on done edge drops enable same edge sub-block returns to IDLE -> no double start.
//  Done pulse and new request in same cycle: go to IDLE first; new grant earliest 1 cycle later.
//  Done from non-granted block ignored. Requests during a grant wait; no preemption (refresh waits).
//  Command mux (comb.): INIT->init bus, AREF->aref, WRITE->wr, READ->rd;
//   IDLE -> NOP 4'b0111, ba 2'b11, addr 13'h1fff.
//  {cs_n,ras_n,cas_n,we_n} = muxed cmd[3:0]; cs_n is bit 3.
//  o_sdram_dq_oe = (state==WRITE) & i_wr_sdram_en; o_sdram_dq_out = oe ? i_wr_sdram_data : 16'd0.
//  Timeout: 10-bit counter cleared in IDLE/INIT, increments in AREF/WRITE/READ;
//   reaching GRANT_TIMEOUT -> IDLE, o_arb_err=1 one cycle.
//  Reset: state=ARB_INIT, counter=0, all enables 0, cke=1, cmd pins=NOP, ba=11, addr=1fff, oe=0, err=0.
//   Reset mid-grant returns to INIT, must see i_init_done again.
// TESTING
//  1 Reset, init_done=0 10 cycles, init_cmd=4'b0010 -> pins follow init bus; all en=0; after init_done=1 -> IDLE, pins NOP.
//  2 aref_req, wr_req, rd_req all high same cycle in IDLE -> o_aref_en next cycle;
//    after aref_done -> 1 IDLE cycle, o_wr_en; after wr_done -> o_rd_en.
//  3 rd grant, i_rd_cmd=4'b0101 ba=2 addr=13'h0005 -> pins 0/1/0/1, ba=2, addr=5;
//    rd_done -> o_rd_en low next cycle, pins NOP.
//  4 Write grant, i_wr_sdram_en=1 data=16'hA5A5 -> dq_oe=1 dq_out=A5A5; wr_sdram_en=0 -> oe=0, dq_out=0.
//  5 Grant read, never pulse rd_done -> after GRANT_TIMEOUT cycles o_arb_err one pulse, state IDLE, o_rd_en=0.
//  6 Assert i_sysrst_n=0 mid-write -> en/oe/err 0 immediately, cke=1, pins NOP; release -> waits in INIT for init_done.

Source files
------------

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Command arbiter in front of the SDRAM pins. After the init sequence reports
// done, the bus is granted to one of the auto-refresh, write or read sub-blocks
// (fixed priority refresh > write > read). The granted block's command, bank
// and address are forwarded to the device pins. The grant enables are level
// signals that the sub-blocks sample in their own IDLE states.
//
// Ports
//   i_sysclk, i_sysrst_n            clock, asynchronous active-low reset
//   i_init_*                        init block: done level + command bus
//   i_aref_* / i_wr_* / i_rd_*      request level, done pulse, command bus
//   i_wr_sdram_en/_data             write data path from the write block
//   o_aref_en/o_wr_en/o_rd_en       grant enables (one-hot or all zero)
//   o_sdram_*                       device command/address/data pins
//   o_arb_err                       one-cycle pulse when a grant times out
// -----------------------------------------------------------------------------
module sdram_arbit #(
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic        i_sysclk,
    input  logic        i_sysrst_n,
    input  logic        i_init_done,
    input  logic [3:0]  i_init_cmd,
    input  logic [1:0]  i_init_ba,
    input  logic [12:0] i_init_addr,
    input  logic        i_aref_req,
    input  logic        i_aref_done,
    input  logic [3:0]  i_aref_cmd,
    input  logic [1:0]  i_aref_ba,
    input  logic [12:0] i_aref_addr,
    input  logic        i_wr_req,
    input  logic        i_wr_done,
    input  logic [3:0]  i_wr_cmd,
    input  logic [1:0]  i_wr_ba,
    input  logic [12:0] i_wr_addr,
    input  logic        i_wr_sdram_en,
    input  logic [15:0] i_wr_sdram_data,
    input  logic        i_rd_req,
    input  logic        i_rd_done,
    input  logic [3:0]  i_rd_cmd,
    input  logic [1:0]  i_rd_ba,
    input  logic [12:0] i_rd_addr,
    output logic        o_aref_en,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic        o_sdram_cke,
    output logic        o_sdram_cs_n,
    output logic        o_sdram_ras_n,
    output logic        o_sdram_cas_n,
    output logic        o_sdram_we_n,
    output logic [1:0]  o_sdram_ba,
    output logic [12:0] o_sdram_addr,
    output logic [15:0] o_sdram_dq_out,
    output logic        o_sdram_dq_oe,
    output logic        o_arb_err
);

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [1:0]  BA_IDLE  = 2'b11;
    localparam logic [12:0] ADR_IDLE = 13'h1fff;
    localparam logic [9:0]  CNT_LAST = 10'(GRANT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ARB_INIT,
        ARB_IDLE,
        ARB_AREF,
        ARB_WRITE,
        ARB_READ
    } arb_state_t;

    arb_state_t  state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        done_sel;

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q <= ARB_INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Only the granted block's done pulse can close a grant.
    always_comb begin
        done_sel = 1'b0;
        case (state_q)
            ARB_AREF:  done_sel = i_aref_done;
            ARB_WRITE: done_sel = i_wr_done;
            ARB_READ:  done_sel = i_rd_done;
            default:   done_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            ARB_INIT: begin
                if (i_init_done) state_d = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (i_aref_req)    state_d = ARB_AREF;
                else if (i_wr_req) state_d = ARB_WRITE;
                else if (i_rd_req) state_d = ARB_READ;
            end
            ARB_AREF, ARB_WRITE, ARB_READ: begin
                // Always pass through IDLE after a grant, so a sub-block that
                // has just returned to its IDLE never sees a stale enable.
                if (done_sel) begin
                    state_d = ARB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ARB_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = ARB_INIT;
        endcase
    end

    assign o_aref_en   = (state_q == ARB_AREF);
    assign o_wr_en     = (state_q == ARB_WRITE);
    assign o_rd_en     = (state_q == ARB_READ);
    assign o_sdram_cke = 1'b1;
    assign o_arb_err   = err_q;

    logic [3:0]  cmd_mux;
    logic [1:0]  ba_mux;
    logic [12:0] addr_mux;

    // While reset is held the pins show NOP rather than the init bus, even
    // though the state register already reads INIT.
    always_comb begin
        cmd_mux  = CMD_NOP;
        ba_mux   = BA_IDLE;
        addr_mux = ADR_IDLE;
        if (i_sysrst_n) begin
            case (state_q)
                ARB_INIT:  begin cmd_mux = i_init_cmd; ba_mux = i_init_ba; addr_mux = i_init_addr; end
                ARB_AREF:  begin cmd_mux = i_aref_cmd; ba_mux = i_aref_ba; addr_mux = i_aref_addr; end
                ARB_WRITE: begin cmd_mux = i_wr_cmd;   ba_mux = i_wr_ba;   addr_mux = i_wr_addr;   end
                ARB_READ:  begin cmd_mux = i_rd_cmd;   ba_mux = i_rd_ba;   addr_mux = i_rd_addr;   end
                default:   begin cmd_mux = CMD_NOP;    ba_mux = BA_IDLE;   addr_mux = ADR_IDLE;    end
            endcase
        end
    end

    assign o_sdram_cs_n  = cmd_mux[3];
    assign o_sdram_ras_n = cmd_mux[2];
    assign o_sdram_cas_n = cmd_mux[1];
    assign o_sdram_we_n  = cmd_mux[0];
    assign o_sdram_ba    = ba_mux;
    assign o_sdram_addr  = addr_mux;

    assign o_sdram_dq_oe  = (state_q == ARB_WRITE) & i_wr_sdram_en;
    assign o_sdram_dq_out = o_sdram_dq_oe ? i_wr_sdram_data : 16'd0;

endmodule
